// File: rtl/maclaurin_series_engine.sv
// maclaurin_series_engine: iterative ln(1+x)/exp/sin/atan Maclaurin evaluator sharing one multiplier
module maclaurin_series_engine #(
    parameter int XW     = 16,
    parameter int NTERMS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [XW-1:0] xBus,
    output logic [XW+1:0] rBus,
    output logic          busy,
    output logic          done
);
    if (NTERMS < 2 || NTERMS > 16) begin : g_bad_nterms
        $error("NTERMS must be in 2..16");
    end

    typedef enum logic [2:0] {IDLE, SQ, INIT, STEP_A, STEP_B} state_t;

    localparam longint unsigned ONE = 64'd1 << XW;

    function automatic logic [XW:0] recip(input int d);
        return (XW+1)'(ONE / 64'(d < 1 ? 1 : d));
    endfunction

    state_t        state, state_d;
    logic [1:0]    mode_r;
    logic [XW-1:0] xr, x2;
    logic [XW:0]   p, ma, mb, mres;
    logic [XW+1:0] acc, acc_n;
    logic [3:0]    k;
    logic [2*XW+1:0] prod;
    logic          last, sub;
    logic [XW:0]   rt [4][16];

    // per-mode reciprocal divisors indexed by k: ln k+1, exp k, sin 2k(2k+1), atan 2k+1
    for (genvar i = 0; i < 16; i++) begin : g_rt
        assign rt[0][i] = recip(i + 1);
        assign rt[1][i] = recip(i);
        assign rt[2][i] = recip(2 * i * (2 * i + 1));
        assign rt[3][i] = recip(2 * i + 1);
    end

    assign prod  = {{(XW+1){1'b0}}, ma} * {{(XW+1){1'b0}}, mb};
    assign mres  = (XW+1)'(prod >> XW);
    assign last  = k == 4'(NTERMS - 1);
    assign sub   = (mode_r != 2'd1) && k[0];
    assign acc_n = sub ? acc - (XW+2)'(mres) : acc + (XW+2)'(mres);

    // shared multiplier operands: x*x in SQ, p*factor in A, p*reciprocal in B
    always_comb begin
        ma = (state == SQ) ? {1'b0, xr} : p;
        mb = (state == SQ) ? {1'b0, xr} :
             (state == STEP_A) ? {1'b0, mode_r[1] ? x2 : xr} : rt[mode_r][k];
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // next-state sequencing
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? SQ : IDLE;
            SQ:      state_d = INIT;
            INIT:    state_d = STEP_A;
            STEP_A:  state_d = STEP_B;
            STEP_B:  state_d = last ? IDLE : STEP_A;
            default: state_d = IDLE;
        endcase
    end

    // datapath: latch operands, square, seed, then alternate power and term steps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r <= '0;
            xr     <= '0;
            x2     <= '0;
            p      <= '0;
            acc    <= '0;
            k      <= '0;
            rBus   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    xr     <= xBus;
                    mode_r <= mode;
                    busy   <= 1'b1;
                end
                SQ: x2 <= mres[XW-1:0];
                INIT: begin
                    p   <= (mode_r == 2'd1) ? (XW+1)'(ONE) : {1'b0, xr};
                    acc <= (mode_r == 2'd1) ? (XW+2)'(ONE) : {2'b0, xr};
                    k   <= 4'd1;
                end
                STEP_A: p <= mres;
                STEP_B: begin
                    acc <= acc_n;
                    if (mode_r[0] ^ mode_r[1]) p <= mres;
                    if (last) begin
                        rBus <= acc_n;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_maclaurin_series_engine.sv
// tb_maclaurin_series_engine: directed checks of series results, timing, start filtering and reset
module tb_maclaurin_series_engine;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, start2 = 1'b0;
    logic [1:0]  mode = 2'd0, mode2 = 2'd0;
    logic [15:0] xbus = 16'd0, xbus2 = 16'd0;
    logic [17:0] rbus, rbus2;
    logic        busy, done, busy2, done2;
    int          n_chk = 0, n_fail = 0;

    maclaurin_series_engine #(.XW(16), .NTERMS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .xBus(xbus),
        .rBus(rbus), .busy(busy), .done(done)
    );

    maclaurin_series_engine #(.XW(16), .NTERMS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .xBus(xbus2),
        .rBus(rbus2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        n_chk++;
        if (got - exp > tol || exp - got > tol) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // one computation on the NTERMS=8 unit; operands are scrambled after acceptance
    task automatic run(input logic [1:0] m, input logic [15:0] x,
                       output logic [17:0] r, output int lat, output int busy_bad);
        @(negedge clk);
        mode = m; xbus = x; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; xbus = ~x;
        lat = 0; busy_bad = 0;
        while (lat < 100) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        r = rbus;
    endtask

    initial begin
        logic [17:0] r;
        int lat, bb, e, first, second, ndone, done_at;

        #12;
        check("reset rbus", rbus, 0, 0);
        check("reset done", done, 0, 0);
        check("reset busy", busy, 0, 0);
        check("reset rbus2", rbus2, 0, 0);
        @(negedge clk); rst = 1'b1;

        run(2'd0, 16'h4000, r, lat, bb);
        check("ln 0x4000", r, 'h03920, 4);
        check("ln latency", lat, 16, 0);
        check("ln busy held", bb, 0, 0);
        check("busy low at done", busy, 0, 0);
        @(posedge clk); #1;
        check("done one cycle", done, 0, 0);

        run(2'd1, 16'h8000, r, lat, bb);
        check("exp 0x8000", r, 'h1A613, 8);
        check("exp latency", lat, 16, 0);
        run(2'd2, 16'hFFFF, r, lat, bb);
        check("sin 0xFFFF", r, 'h0D76A, 8);
        check("sin latency", lat, 16, 0);
        run(2'd3, 16'h4000, r, lat, bb);
        check("atan 0x4000", r, 'h03EB7, 8);
        check("atan latency", lat, 16, 0);

        run(2'd0, 16'h0000, r, lat, bb); check("ln 0", r, 'h00000, 0);
        run(2'd1, 16'h0000, r, lat, bb); check("exp 0", r, 'h10000, 0);
        run(2'd2, 16'h0000, r, lat, bb); check("sin 0", r, 'h00000, 0);
        run(2'd3, 16'h0000, r, lat, bb); check("atan 0", r, 'h00000, 0);

        // extra start pulses at edges 3 and 10 must be ignored
        @(negedge clk);
        mode = 2'd0; xbus = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ndone = 0; done_at = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 10);
            @(posedge clk); #1;
            if (done) begin ndone++; done_at = i; end
        end
        start = 1'b0;
        check("ignored start done count", ndone, 1, 0);
        check("ignored start done edge", done_at, 16, 0);

        // start held high: back-to-back runs, operand swapped after the first done
        @(negedge clk);
        mode = 2'd1; xbus = 16'h8000; start = 1'b1;
        @(posedge clk); #1;
        e = 0; first = -1; second = -1;
        while (e < 60 && second < 0) begin
            @(posedge clk); #1;
            e++;
            if (done) begin
                if (first < 0) begin
                    first = e;
                    check("b2b first result", rbus, 'h1A613, 8);
                    xbus = 16'h0000;
                end else second = e;
            end
        end
        @(negedge clk); start = 1'b0;
        check("b2b first edge", first, 16, 0);
        check("b2b spacing", second - first, 17, 0);
        check("b2b second result", rbus, 'h10000, 0);
        wait (!busy);

        // reset asserted mid-computation at edge 7
        @(negedge clk);
        mode = 2'd0; xbus = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset rbus", rbus, 0, 0);
        check("midreset done", done, 0, 0);
        check("midreset busy", busy, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("no done after reset", ndone, 0, 0);
        run(2'd0, 16'h4000, r, lat, bb);
        check("post-reset ln", r, 'h03920, 4);
        check("post-reset latency", lat, 16, 0);

        // NTERMS=2 build: 1 + x exactly, done at edge 4
        @(negedge clk);
        mode2 = 2'd1; xbus2 = 16'h8000; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done2) break;
        end
        check("n2 exp latency", lat, 4, 0);
        check("n2 exp 0x8000", rbus2, 'h18000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/maclaurin_series_engine.md
# maclaurin_series_engine

- Parametrised, multi-function successor to the single-function ln(1+x) series calculator.
- Evaluates one of four truncated Maclaurin series on an unsigned fractional input: ln(1+x), exp(x), sin(x) or atan(x).
- Uses a single shared multiplier under a start/done iterative FSM.
- Sits behind the same start/xBus/rBus/done handshake as the existing series blocks; width and term count are set at elaboration.

## Interface
- XW, 16: input fraction width; xBus is Q0.XW, x in [0,1).
- NTERMS, 8: total series terms evaluated, legal range 2..16; out-of-range values are an elaboration error.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  0 = ln(1+x), 1 = exp(x), 2 = sin(x), 3 = atan(x); latched with start.
- xBus  in  XW  operand, Q0.XW; latched with start.
- rBus  out  XW+2  result, unsigned Q2.XW; held from done until the next done.
- busy  out  1  high from the start-accept edge until the done edge.
- done  out  1  registered one-cycle pulse when rBus is valid.

## Operation
- Registers
  - xr: latched x.
  - x2 = trunc(xr·xr).
  - p: power/term register, Q1.XW.
  - acc: Q2.XW accumulator.
  - k: iteration counter, 1..NTERMS-1.
- Reciprocal table: r(d) = floor(2^XW / d), XW+1 bits, generated at elaboration.
- Products: full-width multiply, then truncation (floor) to XW fraction bits; no rounding.
- Per-mode init (first term):
  - ln: p = x, acc = x.
  - exp: p = 1.0, acc = 1.0.
  - sin: p = x, acc = x.
  - atan: p = x, acc = x.
- Per iteration k, step A multiplies p by a factor, and step B forms the term.
  - Step A factor: ln and exp use x; sin and atan use x2.
  - ln: term = trunc(p·r(k+1)); p unchanged.
  - exp: p ← trunc(p·r(k)); term = new p.
  - sin: p ← trunc(p·r(2k·(2k+1))); term = new p.
  - atan: term = trunc(p·r(2k+1)); p unchanged.
- Sign: exp always adds. ln, sin and atan subtract the term on odd k and add it on even k.
- acc never goes negative for x in [0,1): terms are monotonically decreasing.
- FSM states:
  - IDLE: start=1 latches xr and mode, sets busy, and goes to SQ.
  - SQ: computes x2, goes to INIT.
  - INIT: loads p and acc, sets k=1, goes to A.
  - A: goes to B.
  - B: updates acc. If k = NTERMS-1 it goes to IDLE, loads rBus ← acc, pulses done and clears busy. Otherwise it increments k and goes to A.
- start while busy is ignored, with no queuing.
- mode and xBus changes while busy have no effect.
- start in the same cycle that done is high is accepted, because the FSM is already in IDLE.

## Timing
- Edge 0 is the edge that samples start=1 in IDLE.
- busy is high after edge 0.
- rBus and done update at edge 2·NTERMS; with the defaults that is edge 16.
- done is high for exactly one cycle; busy is low from that same edge.
- Latency is independent of mode and operand value.
- Back-to-back throughput is one result per 2·NTERMS+1 cycles when start is held high.
- Reset (rst=0) at any time, including mid-computation:
  - FSM returns to IDLE immediately.
  - rBus=0, done=0, busy=0.
  - All internal registers are cleared.
  - No partial result appears after reset releases.
- Reset release: the first start is accepted on the first rising edge with rst=1.

## Test plan
Defaults for all scenarios: XW=16, NTERMS=8. "± n LSB" is the allowed truncation tolerance.
- ln, x=0x4000: rBus = 0x03920 ± 4 LSB, i.e. ln 1.25; done exactly 16 edges after start-accept, busy high throughout.
- exp, x=0x8000: rBus = 0x1A613 ± 8 LSB, i.e. e^0.5. sin, x=0xFFFF: rBus = 0x0D76A ± 8 LSB.
- atan, x=0x4000: rBus = 0x03EB7 ± 8 LSB. Then x=0 in each mode gives ln 0x00000, exp 0x10000, sin 0x00000 and atan 0x00000, all exact.
- start pulsed again at edges 3 and 10 of a computation: ignored, and a single done still arrives at edge 16. Then start is held high: a second done arrives 17 cycles after the first, with the new result.
- rst driven low at edge 7 of a computation: rBus, done and busy are 0 immediately, and no done follows. After release, a new ln x=0x4000 run returns 0x03920 ± 4 LSB on schedule.
- NTERMS=2 build, exp, x=0x8000: rBus = 0x18000 exactly, i.e. 1 + 0.5; done at edge 4.
